// File: rtl/motor_ramp_seq.sv
// Slew-rate limited left/right wheel command sequencer. Sign reversals are forced
// through zero plus a brake dwell; estop brakes both sides immediately.

module motor_ramp_side #(
    parameter int STEP      = 8,
    parameter int BRAKE_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        estop,
    input  logic [10:0] tgt,
    output logic [10:0] cur,
    output logic [10:0] cur_nxt,
    output logic        busy_nxt,
    output logic        brake_nxt
);
    // state    | meaning
    // ST_IDLE  | cur == tgt (or waiting for the next tick to start ramping)
    // ST_RAMP  | stepping cur toward tgt (or toward 0 on a reversal) each tick
    // ST_BRAKE | holding cur at 0 for the reversal dwell
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RAMP  = 2'd1;
    localparam logic [1:0] ST_BRAKE = 2'd2;

    localparam int BW = (BRAKE_CYC > 1) ? $clog2(BRAKE_CYC) : 1;
    localparam logic signed [11:0] STEP_S = 12'(STEP);

    logic [1:0]          st, st_d;
    logic [BW-1:0]       brk_cnt, brk_cnt_d;
    logic [10:0]         n;
    logic signed [11:0]  c, t, up, dn;

    assign c  = {cur[10], cur};
    assign t  = {tgt[10], tgt};
    assign up = c + STEP_S;
    assign dn = c - STEP_S;

    always_comb begin
        n         = cur;
        st_d      = st;
        brk_cnt_d = brk_cnt;
        if (estop) begin
            n         = '0;
            st_d      = ST_IDLE;
            brk_cnt_d = '0;
        end else if (st == ST_BRAKE) begin
            n = '0;
            if (brk_cnt == '0)
                st_d = ST_RAMP;
            else
                brk_cnt_d = brk_cnt - BW'(1);
        end else if (tick && (st == ST_RAMP || c != t)) begin
            if (c != 12'sd0 && t != 12'sd0 && c[11] != t[11]) begin
                // opposite sign: head for zero first, never cross it in one step
                if (c[11])
                    n = (up > 12'sd0) ? 11'd0 : up[10:0];
                else
                    n = (dn < 12'sd0) ? 11'd0 : dn[10:0];
                if (n == 11'd0) begin
                    st_d      = ST_BRAKE;
                    brk_cnt_d = BW'(BRAKE_CYC - 1);
                end else begin
                    st_d = ST_RAMP;
                end
            end else begin
                if (t > c)
                    n = (up > t) ? tgt : up[10:0];
                else
                    n = (dn < t) ? tgt : dn[10:0];
                st_d = (n == tgt) ? ST_IDLE : ST_RAMP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= ST_IDLE;
            cur     <= '0;
            brk_cnt <= '0;
        end else begin
            st      <= st_d;
            cur     <= n;
            brk_cnt <= brk_cnt_d;
        end
    end

    assign cur_nxt   = n;
    assign busy_nxt  = (st_d != ST_IDLE);
    assign brake_nxt = (st_d == ST_BRAKE);
endmodule

module motor_ramp_seq #(
    parameter int STEP       = 8,
    parameter int UPDATE_DIV = 1024,
    parameter int BRAKE_CYC  = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] lft_tgt,
    input  logic [10:0] rht_tgt,
    input  logic        tgt_vld,
    input  logic        estop,
    output logic [10:0] lft,
    output logic [10:0] rht,
    output logic        busy,
    output logic        at_tgt
);
    localparam int CW = $clog2(UPDATE_DIV);

    logic [CW-1:0] cnt;
    logic          tick;
    logic [10:0]   lft_tgt_q, rht_tgt_q, lft_tgt_d, rht_tgt_d;
    logic [10:0]   lft_nxt, rht_nxt;
    logic          lft_busy_d, rht_busy_d, lft_brk_d, rht_brk_d;

    // -1024 has no positive mirror, so it is pulled in to keep the ramp symmetric
    function automatic logic [10:0] sat_tgt(input logic [10:0] v);
        return (v == 11'h400) ? 11'h401 : v;
    endfunction

    assign tick = (cnt == CW'(UPDATE_DIV - 1));

    always_comb begin
        lft_tgt_d = lft_tgt_q;
        rht_tgt_d = rht_tgt_q;
        if (estop) begin
            lft_tgt_d = '0;
            rht_tgt_d = '0;
        end else if (tgt_vld) begin
            lft_tgt_d = sat_tgt(lft_tgt);
            rht_tgt_d = sat_tgt(rht_tgt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            lft_tgt_q <= '0;
            rht_tgt_q <= '0;
            busy      <= 1'b0;
            at_tgt    <= 1'b1;
        end else begin
            cnt       <= ((tgt_vld && !estop) || tick) ? '0 : cnt + CW'(1);
            lft_tgt_q <= lft_tgt_d;
            rht_tgt_q <= rht_tgt_d;
            busy      <= lft_busy_d | rht_busy_d;
            at_tgt    <= (lft_nxt == lft_tgt_d) && (rht_nxt == rht_tgt_d) &&
                         !lft_brk_d && !rht_brk_d;
        end
    end

    motor_ramp_side #(.STEP(STEP), .BRAKE_CYC(BRAKE_CYC)) u_lft (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .estop     (estop),
        .tgt       (lft_tgt_q),
        .cur       (lft),
        .cur_nxt   (lft_nxt),
        .busy_nxt  (lft_busy_d),
        .brake_nxt (lft_brk_d)
    );

    motor_ramp_side #(.STEP(STEP), .BRAKE_CYC(BRAKE_CYC)) u_rht (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .estop     (estop),
        .tgt       (rht_tgt_q),
        .cur       (rht),
        .cur_nxt   (rht_nxt),
        .busy_nxt  (rht_busy_d),
        .brake_nxt (rht_brk_d)
    );
endmodule

// File: tb/tb_motor_ramp_seq.sv
// Bench for motor_ramp_seq: per-cycle reference model feeding a scoreboard queue,
// directed scenarios followed by randomized target/estop traffic.

module tb_motor_ramp_seq;
    localparam int STEP = 8;
    localparam int DIV  = 4;
    localparam int BRK  = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] lft_tgt = '0;
    logic [10:0] rht_tgt = '0;
    logic        tgt_vld = 1'b0;
    logic        estop = 1'b0;
    logic [10:0] lft, rht;
    logic        busy, at_tgt;

    motor_ramp_seq #(.STEP(STEP), .UPDATE_DIV(DIV), .BRAKE_CYC(BRK)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .lft_tgt (lft_tgt),
        .rht_tgt (rht_tgt),
        .tgt_vld (tgt_vld),
        .estop   (estop),
        .lft     (lft),
        .rht     (rht),
        .busy    (busy),
        .at_tgt  (at_tgt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    logic [23:0] exp_q[$];

    // reference model state: speeds as plain integers, brake as remaining cycles
    int m_cur[2];
    int m_tgt[2];
    int m_brk[2];
    bit m_mov[2];
    int m_cnt;
    bit m_tick;

    function automatic int to_int(input logic [10:0] v);
        return int'($signed(v));
    endfunction

    function automatic int sat(input logic [10:0] v);
        int x;
        x = to_int(v);
        return (x == -1024) ? -1023 : x;
    endfunction

    function automatic int move_to(input int from, input int to, input int st);
        if (to > from) return (from + st > to) ? to : from + st;
        return (from - st < to) ? to : from - st;
    endfunction

    function automatic int pick();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 2047)) - 1024;
        return int'($urandom_range(0, 80)) - 40;
    endfunction

    task automatic cmp(input string nm, input logic [23:0] act, input logic [23:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got lft=%0d rht=%0d busy=%0b at_tgt=%0b, want lft=%0d rht=%0d busy=%0b at_tgt=%0b",
                     nm, $time, $signed(act[23:13]), $signed(act[12:2]), act[1], act[0],
                     $signed(exp[23:13]), $signed(exp[12:2]), exp[1], exp[0]);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, want %0d", nm, $time, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int l, input int r, input bit es = 1'b0);
        lft_tgt = 11'(l);
        rht_tgt = 11'(r);
        tgt_vld = 1'b1;
        estop   = es;
        cyc(1);
        tgt_vld = 1'b0;
    endtask

    // reference model: evaluated on every active edge, expected outputs queued
    initial begin
        for (int i = 0; i < 2; i++) begin
            m_cur[i] = 0; m_tgt[i] = 0; m_brk[i] = 0; m_mov[i] = 0;
        end
        m_cnt = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 2; i++) begin
                    m_cur[i] = 0; m_tgt[i] = 0; m_brk[i] = 0; m_mov[i] = 0;
                end
                m_cnt = 0;
                exp_q.delete();
            end else begin
                m_tick = (m_cnt == DIV - 1);
                for (int i = 0; i < 2; i++) begin
                    if (estop) begin
                        m_cur[i] = 0; m_tgt[i] = 0; m_brk[i] = 0; m_mov[i] = 0;
                    end else if (m_brk[i] > 0) begin
                        m_brk[i]--;
                        if (m_brk[i] == 0) m_mov[i] = 1;
                    end else if (m_tick && (m_mov[i] || m_cur[i] != m_tgt[i])) begin
                        if (m_cur[i] != 0 && m_tgt[i] != 0 && ((m_cur[i] < 0) != (m_tgt[i] < 0))) begin
                            m_cur[i] = move_to(m_cur[i], 0, STEP);
                            if (m_cur[i] == 0) begin
                                m_brk[i] = BRK;
                                m_mov[i] = 0;
                            end else begin
                                m_mov[i] = 1;
                            end
                        end else begin
                            m_cur[i] = move_to(m_cur[i], m_tgt[i], STEP);
                            m_mov[i] = (m_cur[i] != m_tgt[i]);
                        end
                    end
                end
                if (!estop && tgt_vld) begin
                    m_tgt[0] = sat(lft_tgt);
                    m_tgt[1] = sat(rht_tgt);
                end
                m_cnt = (tgt_vld && !estop) ? 0 : (m_tick ? 0 : m_cnt + 1);
                exp_q.push_back({11'(m_cur[0]), 11'(m_cur[1]),
                                 m_mov[0] || m_mov[1] || m_brk[0] > 0 || m_brk[1] > 0,
                                 m_cur[0] == m_tgt[0] && m_cur[1] == m_tgt[1] &&
                                 m_brk[0] == 0 && m_brk[1] == 0});
            end
        end
    end

    // monitor: outputs sampled mid-cycle against the oldest queued expectation
    initial begin
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n || exp_q.size() == 0) begin
                cmp("reset_state", {lft, rht, busy, at_tgt}, 24'h1);
            end else begin
                e = exp_q.pop_front();
                cmp("scoreboard", {lft, rht, busy, at_tgt}, e);
            end
        end
    end

    initial begin
        int l, r;
        cyc(3);
        rst_n = 1'b1;
        chk("rst_lft", to_int(lft), 0);
        chk("rst_at_tgt", int'(at_tgt), 1);
        cyc(20);
        chk("idle_busy", int'(busy), 0);
        chk("idle_at_tgt", int'(at_tgt), 1);

        strobe(20, -12);
        cyc(4);
        chk("ramp_lft_1", to_int(lft), 8);
        chk("ramp_rht_1", to_int(rht), -8);
        cyc(4);
        chk("ramp_lft_2", to_int(lft), 16);
        chk("ramp_rht_2", to_int(rht), -12);
        chk("ramp_busy", int'(busy), 1);
        cyc(4);
        chk("ramp_lft_3", to_int(lft), 20);
        chk("ramp_at_tgt", int'(at_tgt), 1);
        chk("ramp_busy_done", int'(busy), 0);

        strobe(16, -12);
        cyc(12);
        chk("rev_start", to_int(lft), 16);
        strobe(-8, -12);
        cyc(4);
        chk("rev_lft_8", to_int(lft), 8);
        cyc(4);
        chk("rev_lft_0", to_int(lft), 0);
        for (int k = 0; k < 7; k++) begin
            cyc(1);
            chk("brake_hold", to_int(lft), 0);
            chk("brake_at_tgt", int'(at_tgt), 0);
        end
        cyc(1);
        chk("rev_lft_neg", to_int(lft), -8);

        strobe(0, 0);
        cyc(16);
        strobe(100, 0);
        cyc(20);
        chk("estop_pre", to_int(lft), 40);
        estop = 1'b1;
        cyc(1);
        chk("estop_lft", to_int(lft), 0);
        chk("estop_busy", int'(busy), 0);
        cyc(3);
        estop = 1'b0;
        cyc(20);
        chk("estop_after", to_int(lft), 0);

        strobe(-1024, 0);
        cyc(4 * 127);
        chk("sat_mid", to_int(lft), -1016);
        cyc(4);
        chk("sat_end", to_int(lft), -1023);
        cyc(8);
        chk("sat_hold", to_int(lft), -1023);

        strobe(50, 0, 1'b1);
        chk("vld_estop_lft", to_int(lft), 0);
        cyc(2);
        estop = 1'b0;
        cyc(20);
        chk("vld_estop_after", to_int(lft), 0);

        strobe(60, -60);
        cyc(10);
        rst_n = 1'b0;
        #1;
        chk("async_rst_lft", to_int(lft), 0);
        chk("async_rst_rht", to_int(rht), 0);
        cyc(3);
        rst_n = 1'b1;
        cyc(2);

        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                estop = 1'b1;
                cyc($urandom_range(1, 3));
                estop = 1'b0;
            end
            l = pick();
            r = pick();
            strobe(l, r, ($urandom_range(0, 19) == 0));
            estop = 1'b0;
            cyc($urandom_range(0, 40));
        end
        cyc(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
